// File: rtl/mem_wb_pipe_pkg.sv
// Shared definitions for the MEM/WB stage and the load formatter.
// Load func3 encodings and XLEN-derived helpers.
package mem_wb_pipe_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;
    localparam logic [2:0] F3_RAW = 3'b111;

    function automatic int off_w(input int xlen);
        return $clog2(xlen / 8);
    endfunction

    function automatic bit xlen_legal(input int xlen);
        return (xlen == 32) || (xlen == 64);
    endfunction

endpackage

// File: rtl/mem_wb_pipe_load_extend.sv
// Combinational load formatter: raw aligned word + byte offset + func3
// -> extended load data and misalignment flag.
module load_extend
    import mem_wb_pipe_pkg::*;
#(
    parameter int XLEN = 32,
    localparam int OFF_W = off_w(XLEN)
) (
    input  logic [XLEN-1:0]  raw_i,
    input  logic [OFF_W-1:0] off_i,
    input  logic [2:0]       func3_i,
    output logic [XLEN-1:0]  data_o,
    output logic             misalign_o
);

    localparam bit IS64 = (XLEN == 64);

    logic [OFF_W+2:0] sh_amt;
    logic [7:0]       b;
    logic [15:0]      h;
    logic [31:0]      w;
    logic             w_mis;

    assign sh_amt = {off_i, 3'b000};
    assign b      = 8'(raw_i >> sh_amt);
    assign h      = 16'(raw_i >> sh_amt);
    assign w      = 32'(raw_i >> sh_amt);
    assign w_mis  = (off_i[1:0] != 2'b00);

    always_comb begin
        data_o     = raw_i;
        misalign_o = 1'b0;
        case (func3_i)
            F3_LB:  data_o = XLEN'($signed(b));
            F3_LBU: data_o = XLEN'(b);
            F3_LH: begin
                data_o     = XLEN'($signed(h));
                misalign_o = off_i[0];
            end
            F3_LHU: begin
                data_o     = XLEN'(h);
                misalign_o = off_i[0];
            end
            F3_LW: begin
                if (IS64) data_o = XLEN'($signed(w));
                misalign_o = w_mis;
            end
            F3_LWU: begin
                // RV32 has no LWU: behaves as LW
                if (IS64) data_o = XLEN'(w);
                misalign_o = w_mis;
            end
            F3_LD: begin
                if (IS64) misalign_o = |off_i;
                else      misalign_o = w_mis;
            end
            default: data_o = raw_i;
        endcase
    end

endmodule

// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline register with stall/flush, load formatting,
// qualified register-file write and retired-instruction counter.
module mem_wb_pipe
    import mem_wb_pipe_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int RA_W  = 5,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             me_valid,
    output logic             me_ready,
    input  logic [XLEN-1:0]  me_mem_data,
    input  logic [XLEN-1:0]  me_alu_o,
    input  logic [RA_W-1:0]  me_rd,
    input  logic             me_mem2reg,
    input  logic             me_regs_write,
    input  logic [2:0]       me_func3_code,
    input  logic             flush,
    input  logic             wb_ready,
    output logic             wb_valid,
    output logic [RA_W-1:0]  wb_rd,
    output logic             wb_we,
    output logic [XLEN-1:0]  wb_wdata,
    output logic [XLEN-1:0]  wb_alu_o,
    output logic             wb_misalign,
    output logic [CNT_W-1:0] retire_cnt
);

    localparam int OFF_W = off_w(XLEN);

    if (!xlen_legal(XLEN)) begin : g_bad_xlen
        $error("mem_wb_pipe: XLEN must be 32 or 64");
    end

    logic             valid_q, valid_d;
    logic [XLEN-1:0]  mem_data_q, mem_data_d;
    logic [XLEN-1:0]  alu_q, alu_d;
    logic [RA_W-1:0]  rd_q, rd_d;
    logic             mem2reg_q, mem2reg_d;
    logic             regs_write_q, regs_write_d;
    logic [2:0]       func3_q, func3_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [XLEN-1:0]  ld_data;
    logic             ld_mis;

    assign me_ready = !valid_q || wb_ready;

    always_comb begin
        valid_d      = valid_q;
        mem_data_d   = mem_data_q;
        alu_d        = alu_q;
        rd_d         = rd_q;
        mem2reg_d    = mem2reg_q;
        regs_write_d = regs_write_q;
        func3_d      = func3_q;
        cnt_d        = cnt_q + CNT_W'(valid_q && wb_ready);
        if (flush) begin
            valid_d = 1'b0;
        end else if (me_ready) begin
            valid_d = me_valid;
            if (me_valid) begin
                mem_data_d   = me_mem_data;
                alu_d        = me_alu_o;
                rd_d         = me_rd;
                mem2reg_d    = me_mem2reg;
                regs_write_d = me_regs_write;
                func3_d      = me_func3_code;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q      <= 1'b0;
            mem_data_q   <= '0;
            alu_q        <= '0;
            rd_q         <= '0;
            mem2reg_q    <= 1'b0;
            regs_write_q <= 1'b0;
            func3_q      <= 3'b000;
            cnt_q        <= '0;
        end else begin
            valid_q      <= valid_d;
            mem_data_q   <= mem_data_d;
            alu_q        <= alu_d;
            rd_q         <= rd_d;
            mem2reg_q    <= mem2reg_d;
            regs_write_q <= regs_write_d;
            func3_q      <= func3_d;
            cnt_q        <= cnt_d;
        end
    end

    load_extend #(.XLEN(XLEN)) u_load_extend (
        .raw_i      (mem_data_q),
        .off_i      (alu_q[OFF_W-1:0]),
        .func3_i    (func3_q),
        .data_o     (ld_data),
        .misalign_o (ld_mis)
    );

    assign wb_valid    = valid_q;
    assign wb_rd       = rd_q;
    assign wb_alu_o    = alu_q;
    assign wb_misalign = valid_q && mem2reg_q && ld_mis;
    assign wb_we       = valid_q && regs_write_q && (rd_q != '0)
                         && !wb_misalign;
    assign wb_wdata    = mem2reg_q ? ld_data : alu_q;
    assign retire_cnt  = cnt_q;

endmodule
